// File: rtl/uart_rx_loader.sv
// UART receiver that captures serial words into a flat instruction-memory image.
// Latency: RX pin to word write is 2 sync cycles + frame time + 1 commit cycle.
// No backpressure: words arriving while the image is full are dropped and flagged via ovf.
module uart_rx_loader #(
  parameter int CLKS_PER_BIT = 2604,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int MEM_WORDS    = 32,
  parameter int ADDR_W       = 5
) (
  input  logic                           i_Clk,
  input  logic                           i_Reset,
  input  logic                           i_RX,
  input  logic                           i_Load,
  output logic [MEM_WORDS*DATA_BITS-1:0] o_memory_ins,
  output logic [ADDR_W-1:0]              o_addr,
  output logic                           o_byte_valid,
  output logic                           o_FE,
  output logic                           o_PE,
  output logic                           o_full,
  output logic                           o_ovf,
  output logic                           o_busy
);

  localparam int TMR_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int CNT_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [TMR_W-1:0]  TMR_HALF  = TMR_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TMR_W-1:0]  TMR_LAST  = TMR_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0]  BIT_LAST  = CNT_W'(DATA_BITS - 1);
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(MEM_WORDS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  // Synchroniser and edge-detect registers
  logic r_rx_s1;
  logic r_rx_s2;
  logic r_rx_d;
  logic r_load_d;

  // Frame FSM and datapath registers
  state_t                 r_state;
  logic [TMR_W-1:0]       r_tmr;
  logic [CNT_W-1:0]       r_bcnt;
  logic [DATA_BITS-1:0]   r_shift;
  logic                   r_perr;
  logic                   r_done;
  logic                   r_stop;

  // Output-side registers
  logic [MEM_WORDS*DATA_BITS-1:0] r_mem;
  logic [ADDR_W-1:0]              r_addr;
  logic                           r_bv;
  logic                           r_fe;
  logic                           r_pe;
  logic                           r_full;
  logic                           r_ovf;

  // Next-state wires
  state_t               w_state_nxt;
  logic [TMR_W-1:0]     w_tmr_nxt;
  logic [CNT_W-1:0]     w_bcnt_nxt;
  logic [DATA_BITS-1:0] w_shift_nxt;
  logic                 w_perr_nxt;
  logic                 w_done;
  logic                 w_tmr_last;
  logic                 w_rx_fall;
  logic                 w_load_rise;
  logic                 w_good;

  assign w_rx_fall   = r_rx_d & ~r_rx_s2;
  assign w_load_rise = i_Load & ~r_load_d;
  assign w_tmr_last  = (r_tmr == TMR_LAST);
  assign w_good      = r_stop & ~r_perr;

  // Two-flop synchroniser on RX plus one-cycle delayed copies for edge detection.
  // The synchroniser idles high so reset never fabricates a start edge.
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      r_rx_s1  <= 1'b1;
      r_rx_s2  <= 1'b1;
      r_rx_d   <= 1'b1;
      r_load_d <= 1'b0;
    end else begin
      r_rx_s1  <= i_RX;
      r_rx_s2  <= r_rx_s1;
      r_rx_d   <= r_rx_s2;
      r_load_d <= i_Load;
    end
  end

  // Next-state and datapath decode for the frame FSM.
  always_comb begin
    w_state_nxt = r_state;
    w_tmr_nxt   = r_tmr + 1'b1;
    w_bcnt_nxt  = r_bcnt;
    w_shift_nxt = r_shift;
    w_perr_nxt  = r_perr;
    w_done      = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_tmr_nxt = '0;
        if (w_rx_fall) begin
          w_state_nxt = S_START;
        end
      end
      S_START: begin
        if (r_tmr == TMR_HALF) begin
          w_tmr_nxt = '0;
          if (r_rx_s2) begin
            // Line went back high before mid start bit: treat as noise.
            w_state_nxt = S_IDLE;
          end else begin
            w_state_nxt = S_DATA;
            w_bcnt_nxt  = '0;
            w_perr_nxt  = 1'b0;
          end
        end
      end
      S_DATA: begin
        if (w_tmr_last) begin
          w_tmr_nxt                   = '0;
          w_shift_nxt                 = r_shift >> 1;
          w_shift_nxt[DATA_BITS-1]    = r_rx_s2;
          if (r_bcnt == BIT_LAST) begin
            w_state_nxt = (PARITY_EN != 0) ? S_PARITY : S_STOP;
          end else begin
            w_bcnt_nxt = r_bcnt + 1'b1;
          end
        end
      end
      S_PARITY: begin
        if (w_tmr_last) begin
          w_tmr_nxt   = '0;
          w_perr_nxt  = ((^r_shift) ^ r_rx_s2) != (PARITY_ODD != 0);
          w_state_nxt = S_STOP;
        end
      end
      S_STOP: begin
        if (w_tmr_last) begin
          w_tmr_nxt   = '0;
          w_done      = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_tmr_nxt   = '0;
      end
    endcase
    // Receive disabled or session restart: abandon any partial frame.
    if (!i_Load || w_load_rise) begin
      w_state_nxt = S_IDLE;
      w_tmr_nxt   = '0;
      w_done      = 1'b0;
    end
  end

  // Frame FSM state, bit timer, bit counter, shift register and stop-bit capture.
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      r_state <= S_IDLE;
      r_tmr   <= '0;
      r_bcnt  <= '0;
      r_shift <= '0;
      r_perr  <= 1'b0;
      r_done  <= 1'b0;
      r_stop  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_tmr   <= w_tmr_nxt;
      r_bcnt  <= w_bcnt_nxt;
      r_shift <= w_shift_nxt;
      r_perr  <= w_perr_nxt;
      r_done  <= w_done;
      if (w_done) begin
        r_stop <= r_rx_s2;
      end
    end
  end

  // Commit a finished frame one edge after its stop sample: write, status pulses, full/ovf.
  always_ff @(posedge i_Clk) begin
    if (i_Reset || w_load_rise) begin
      r_mem  <= '0;
      r_addr <= '0;
      r_bv   <= 1'b0;
      r_fe   <= 1'b0;
      r_pe   <= 1'b0;
      r_full <= 1'b0;
      r_ovf  <= 1'b0;
    end else begin
      r_bv <= 1'b0;
      r_fe <= 1'b0;
      r_pe <= 1'b0;
      if (r_done) begin
        r_fe <= ~r_stop;
        r_pe <= r_perr;
        if (w_good) begin
          if (r_full) begin
            r_ovf <= 1'b1;
          end else begin
            for (int k = 0; k < MEM_WORDS; k++) begin
              if (r_addr == ADDR_W'(k)) begin
                r_mem[k*DATA_BITS +: DATA_BITS] <= r_shift;
              end
            end
            r_addr <= r_addr + 1'b1;
            r_bv   <= 1'b1;
            r_full <= (r_addr == ADDR_LAST);
          end
        end
      end
    end
  end

  assign o_memory_ins = r_mem;
  assign o_addr       = r_addr;
  assign o_byte_valid = r_bv;
  assign o_FE         = r_fe;
  assign o_PE         = r_pe;
  assign o_full       = r_full;
  assign o_ovf        = r_ovf;
  assign o_busy       = (r_state != S_IDLE);

endmodule

// File: tb/tb_uart_rx_loader.sv
// Bench for uart_rx_loader: instance A without parity, instance B with even parity.
// Frames are driven bit by bit at 16 clocks per bit; outcomes are compared with a
// word-level model of the loader (memory image, write count, full/overflow, pulse counts).
module tb_uart_rx_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        load;
  logic        rx_a;
  logic        rx_b;

  logic [31:0] mem_a, mem_b;
  logic [2:0]  addr_a, addr_b;
  logic        bv_a, fe_a, pe_a, full_a, ovf_a, busy_a;
  logic        bv_b, fe_b, pe_b, full_b, ovf_b, busy_b;

  int checks = 0;
  int errors = 0;

  // pulse counters, written only by the monitor below
  int n_bv[2];
  int n_fe[2];
  int n_pe[2];

  // word-level model
  logic [7:0] mw[2][4];
  int         ma[2];
  bit         mfull[2];
  bit         movf[2];

  always #5 clk = ~clk;

  uart_rx_loader #(.CLKS_PER_BIT(16), .DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0),
                   .MEM_WORDS(4), .ADDR_W(3)) dut_a (
    .i_Clk(clk), .i_Reset(rst), .i_RX(rx_a), .i_Load(load),
    .o_memory_ins(mem_a), .o_addr(addr_a), .o_byte_valid(bv_a), .o_FE(fe_a),
    .o_PE(pe_a), .o_full(full_a), .o_ovf(ovf_a), .o_busy(busy_a));

  uart_rx_loader #(.CLKS_PER_BIT(16), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0),
                   .MEM_WORDS(4), .ADDR_W(3)) dut_b (
    .i_Clk(clk), .i_Reset(rst), .i_RX(rx_b), .i_Load(load),
    .o_memory_ins(mem_b), .o_addr(addr_b), .o_byte_valid(bv_b), .o_FE(fe_b),
    .o_PE(pe_b), .o_full(full_b), .o_ovf(ovf_b), .o_busy(busy_b));

  initial begin
    for (int i = 0; i < 2; i++) begin
      n_bv[i] = 0; n_fe[i] = 0; n_pe[i] = 0;
    end
  end

  always @(negedge clk) begin
    if (bv_a) n_bv[0]++;
    if (fe_a) n_fe[0]++;
    if (pe_a) n_pe[0]++;
    if (bv_b) n_bv[1]++;
    if (fe_b) n_fe[1]++;
    if (pe_b) n_pe[1]++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int s = 0; s < 2; s++) begin
      for (int k = 0; k < 4; k++) mw[s][k] = 8'h00;
      ma[s] = 0; mfull[s] = 1'b0; movf[s] = 1'b0;
    end
  endtask

  function automatic logic [31:0] exp_mem(input int s);
    logic [31:0] r;
    for (int k = 0; k < 4; k++) r[k*8 +: 8] = mw[s][k];
    return r;
  endfunction

  function automatic logic busy_of(input int s);
    return (s == 0) ? busy_a : busy_b;
  endfunction

  task automatic set_rx(input int s, input logic v);
    if (s == 0) rx_a = v; else rx_b = v;
  endtask

  task automatic check_state(input int s, input string tag);
    chk({tag, "_mem"},  (s == 0) ? mem_a : mem_b, exp_mem(s));
    chk({tag, "_addr"}, (s == 0) ? addr_a : addr_b, ma[s]);
    chk({tag, "_full"}, (s == 0) ? full_a : full_b, mfull[s]);
    chk({tag, "_ovf"},  (s == 0) ? ovf_a : ovf_b, movf[s]);
    chk({tag, "_busy"}, busy_of(s), 1'b0);
  endtask

  // Drive one frame on instance s. cut_kind 1 drops Load, 2 raises Reset, at bit cut_at.
  task automatic send_frame(input int s, input logic [7:0] d, input logic p, input logic stop,
                            input int cut_at, input int cut_kind, input string tag);
    logic [10:0] bits;
    int nb, bv0, fe0, pe0;
    bit fe_exp, pe_exp, good, bv_exp;
    bits = 11'h7FF;
    bits[0] = 1'b0;
    bits[8:1] = d;
    if (s == 1) begin
      bits[9] = p; bits[10] = stop; nb = 11;
    end else begin
      bits[9] = stop; nb = 10;
    end
    bv0 = n_bv[s]; fe0 = n_fe[s]; pe0 = n_pe[s];
    for (int i = 0; i < nb; i++) begin
      set_rx(s, bits[i]);
      if (i == cut_at) begin
        if (cut_kind == 1) load = 1'b0; else rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk({tag, "_cut_busy"}, busy_of(s), 1'b0);
        repeat (15) @(posedge clk);
        #1;
      end else begin
        repeat (16) @(posedge clk);
        #1;
      end
    end
    set_rx(s, 1'b1);
    repeat (48) @(posedge clk);
    @(negedge clk);
    if (cut_at >= 0) begin
      chk({tag, "_bv_n"}, n_bv[s] - bv0, 0);
      chk({tag, "_fe_n"}, n_fe[s] - fe0, 0);
      chk({tag, "_pe_n"}, n_pe[s] - pe0, 0);
    end else begin
      fe_exp = !stop;
      pe_exp = (s == 1) && (($countones({d, p}) % 2) != 0);
      good   = stop && !pe_exp;
      bv_exp = good && !mfull[s];
      if (good) begin
        if (ma[s] < 4) begin
          mw[s][ma[s]] = d;
          ma[s]++;
          if (ma[s] == 4) mfull[s] = 1'b1;
        end else begin
          movf[s] = 1'b1;
        end
      end
      chk({tag, "_bv_n"}, n_bv[s] - bv0, bv_exp);
      chk({tag, "_fe_n"}, n_fe[s] - fe0, fe_exp);
      chk({tag, "_pe_n"}, n_pe[s] - pe0, pe_exp);
    end
    if (cut_kind != 2) check_state(s, tag);
  endtask

  task automatic load_restart();
    load = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    load = 1'b1;
    model_clear();
    repeat (4) @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    logic [7:0] d;
    logic       p;
    logic       st;
    int         bv0, fe0;
    rst = 1'b1; load = 1'b0; rx_a = 1'b1; rx_b = 1'b1;
    model_clear();
    repeat (5) @(posedge clk);
    @(negedge clk);
    check_state(0, "rst_a");
    check_state(1, "rst_b");
    chk("rst_bv_a", bv_a, 1'b0);
    chk("rst_fe_a", fe_a, 1'b0);
    chk("rst_pe_b", pe_b, 1'b0);

    rst = 1'b0;
    load = 1'b1;
    repeat (4) @(posedge clk);
    #1;

    // single good word
    send_frame(0, 8'hA5, 1'b0, 1'b1, -1, 0, "a5");
    // frame error then a normal frame
    send_frame(0, 8'h3C, 1'b0, 1'b0, -1, 0, "fe3c");
    send_frame(0, 8'h11, 1'b0, 1'b1, -1, 0, "w11");

    // short low glitch must not start a frame
    bv0 = n_bv[0]; fe0 = n_fe[0];
    rx_a = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("glitch_busy_hi", busy_a, 1'b1);
    #1 rx_a = 1'b1;
    repeat (30) @(posedge clk);
    @(negedge clk);
    chk("glitch_bv_n", n_bv[0] - bv0, 0);
    chk("glitch_fe_n", n_fe[0] - fe0, 0);
    check_state(0, "glitch");

    // random frames, mostly good
    for (int i = 0; i < 4; i++) begin
      d  = 8'($urandom);
      st = ($urandom_range(0, 3) != 0);
      send_frame(0, d, 1'b0, st, -1, 0, "rnd_a");
    end

    // restart session, then fill and overflow
    load_restart();
    check_state(0, "restart_a");
    for (int i = 1; i <= 5; i++) begin
      send_frame(0, 8'(i), 1'b0, 1'b1, -1, 0, "fill");
    end

    // parity instance: bad parity then good parity for 0x03
    send_frame(1, 8'h03, 1'b1, 1'b1, -1, 0, "par_bad");
    send_frame(1, 8'h03, 1'b0, 1'b1, -1, 0, "par_ok");
    send_frame(1, 8'h07, 1'b0, 1'b0, -1, 0, "par_fe_pe");
    for (int i = 0; i < 4; i++) begin
      d  = 8'($urandom);
      p  = 1'($urandom);
      st = ($urandom_range(0, 4) != 0);
      send_frame(1, d, p, st, -1, 0, "rnd_b");
    end

    // Load dropped mid-frame keeps prior words
    load_restart();
    send_frame(0, 8'h5A, 1'b0, 1'b1, -1, 0, "pre_drop");
    send_frame(0, 8'hC3, 1'b0, 1'b1, 4, 1, "drop");
    load_restart();
    check_state(0, "reload_a");
    check_state(1, "reload_b");

    // Reset asserted mid-data clears everything
    send_frame(0, 8'h77, 1'b0, 1'b1, -1, 0, "pre_rst");
    send_frame(0, 8'hE1, 1'b0, 1'b1, 3, 2, "rst_mid");
    model_clear();
    check_state(0, "in_rst_a");
    check_state(1, "in_rst_b");
    rst = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check_state(0, "post_rst_a");
    send_frame(0, 8'h9E, 1'b0, 1'b1, -1, 0, "post_rst_w");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
